mem_latency_slave: RTL and testbench

Simulated word-addressed memory that sits directly downstream of axi4_lite_top on its memory-side port, in place of a zero-latency array.
- Adds a programmable access latency, with a 4-phase request/done handshake.
- Checks address range and alignment.
- Drives the successful_access / successful_read / successful_write status that the AXI4-Lite master converts into read and write faults.

---
 rtl/mem_latency_pkg.sv | 21 ++
 rtl/mem_stall_lfsr.sv | 24 ++
 rtl/mem_latency_slave.sv | 156 +++++++++++++++
 tb/tb_mem_latency_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_latency_pkg.sv
// Shared types and constants for the latency-modelling memory slave.
// Holds the FSM state encoding, the byte-offset width and the stall LFSR constants.
package mem_latency_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BYTE_OFF_W = 2;

    // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mem_stall_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying 0..3 extra wait cycles per access.
// Only instantiated when MEM_RANDOM_STALL_EN is defined.
module mem_stall_lfsr
    import mem_latency_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_arst,
    output logic [1:0] o_stall
);

    logic [15:0] lfsr_r;

    // Advance the LFSR every cycle, reseeding on reset.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign o_stall = lfsr_r[1:0];

endmodule

// File: rtl/mem_latency_slave.sv
// Word-addressed memory model with programmable access latency and a 4-phase req/done handshake.
// Optional random extra stall cycles are enabled by defining MEM_RANDOM_STALL_EN.
module mem_latency_slave
    import mem_latency_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    LATENCY    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_req,
    input  logic                  i_write_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_done,
    output logic                  o_successful_access,
    output logic                  o_successful_read,
    output logic                  o_successful_write
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = 9;

    state_t                  state_r;
    logic                    pending_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    we_r;
    logic                    ok_r;
    logic [IDX_W-1:0]        idx_r;
    logic [DATA_WIDTH-1:0]   data_r;

    logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   off_s;
    logic                    ok_s;
    logic [IDX_W-1:0]        idx_s;
    logic [1:0]              extra_s;
    logic [CNT_W-1:0]        load_s;
    logic                    enter_resp_s;
    logic                    mem_we_s;
    logic [DATA_WIDTH-1:0]   resp_rdata_s;

`ifdef MEM_RANDOM_STALL_EN
    mem_stall_lfsr u_stall_lfsr (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .o_stall (extra_s)
    );
`else
    assign extra_s = 2'd0;
`endif

    // Range and alignment check at full address width; index is narrowed only afterwards.
    always_comb begin
        off_s = i_addr - BASE_ADDR;
        ok_s  = (i_addr[BYTE_OFF_W-1:0] == {BYTE_OFF_W{1'b0}})
             && (i_addr >= BASE_ADDR)
             && ((off_s >> BYTE_OFF_W) < ADDR_WIDTH'(MEM_DEPTH));
        idx_s = off_s[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
    end

    // Decide whether the coming edge completes the access and what it returns.
    always_comb begin
        load_s       = CNT_W'(LATENCY) + {{(CNT_W-2){1'b0}}, extra_s};
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE:    enter_resp_s = pending_r && (load_s == {CNT_W{1'b0}});
            WAIT:    enter_resp_s = (cnt_r == CNT_W'(1));
            default: enter_resp_s = 1'b0;
        endcase
        mem_we_s = enter_resp_s && we_r && ok_r;
        if (ok_r) begin
            resp_rdata_s = mem_r[idx_r];
        end else begin
            resp_rdata_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Storage is deliberately left out of reset so contents survive a reset.
    always_ff @(posedge i_clk) begin
        if (mem_we_s) begin
            mem_r[idx_r] <= data_r;
        end
    end

    // Handshake FSM: sample request, count latency, present and hold the response.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_r             <= IDLE;
            pending_r           <= 1'b0;
            cnt_r               <= {CNT_W{1'b0}};
            we_r                <= 1'b0;
            ok_r                <= 1'b0;
            idx_r               <= {IDX_W{1'b0}};
            data_r              <= {DATA_WIDTH{1'b0}};
            o_read_data         <= {DATA_WIDTH{1'b0}};
            o_done              <= 1'b0;
            o_successful_access <= 1'b0;
            o_successful_read   <= 1'b0;
            o_successful_write  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pending_r) begin
                        pending_r <= 1'b0;
                        cnt_r     <= load_s;
                        state_r   <= enter_resp_s ? RESP : WAIT;
                    end else if (i_req) begin
                        pending_r <= 1'b1;
                        we_r      <= i_write_en;
                        ok_r      <= ok_s;
                        idx_r     <= idx_s;
                        data_r    <= i_data;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (enter_resp_s) begin
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    // A held request never re-triggers: exit only once it drops.
                    if (!i_req) begin
                        state_r             <= IDLE;
                        o_done              <= 1'b0;
                        o_successful_access <= 1'b0;
                        o_successful_read   <= 1'b0;
                        o_successful_write  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    pending_r <= 1'b0;
                end
            endcase

            if (enter_resp_s) begin
                o_done              <= 1'b1;
                o_successful_access <= ok_r;
                o_successful_read   <= ok_r & ~we_r;
                o_successful_write  <= ok_r & we_r;
                if (we_r && ok_r) begin
                    o_read_data <= o_read_data;
                end else begin
                    o_read_data <= resp_rdata_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_latency_slave.sv
// Directed table-driven bench for mem_latency_slave (LATENCY=4 and LATENCY=0 instances).
// Random-stall scoreboard run is added when MEM_RANDOM_STALL_EN is defined.
module tb_mem_latency_slave;

`ifdef MEM_RANDOM_STALL_EN
    localparam int STALL_MAX = 3;
`else
    localparam int STALL_MAX = 0;
`endif

    logic        clk = 1'b0;
    logic        arst [2];
    logic        req  [2];
    logic        we   [2];
    logic [63:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] rdata[2];
    logic        done [2];
    logic        acc  [2];
    logic        rd   [2];
    logic        wr   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_latency_slave #(.LATENCY(4)) u_lat4 (
        .i_clk(clk), .i_arst(arst[0]), .i_req(req[0]), .i_write_en(we[0]),
        .i_addr(addr[0]), .i_data(wd[0]), .o_read_data(rdata[0]), .o_done(done[0]),
        .o_successful_access(acc[0]), .o_successful_read(rd[0]), .o_successful_write(wr[0])
    );

    mem_latency_slave #(.LATENCY(0)) u_lat0 (
        .i_clk(clk), .i_arst(arst[1]), .i_req(req[1]), .i_write_en(we[1]),
        .i_addr(addr[1]), .i_data(wd[1]), .o_read_data(rdata[1]), .o_done(done[1]),
        .o_successful_access(acc[1]), .o_successful_read(rd[1]), .o_successful_write(wr[1])
    );

    typedef struct {
        int          u;
        logic        w;
        logic [63:0] a;
        logic [31:0] d;
        int          lat;
        logic        acc;
        logic        rd;
        logic        wr;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_lat(input string name, input int lat, input int lo);
        checks++;
        if (lat < lo || lat > lo + STALL_MAX) begin
            errors++;
            $display("FAIL %s: latency %0d edges, expected %0d..%0d", name, lat, lo, lo + STALL_MAX);
        end
    endtask

    // One complete handshake; lat = edges from accepting edge to done (-1 on timeout).
    task automatic do_access(input int u, input logic w, input logic [63:0] a, input logic [31:0] d,
                             output int lat, output logic o_acc, output logic o_rd,
                             output logic o_wr, output logic [31:0] o_rdata, output logic cleared);
        @(negedge clk);
        req[u] = 1'b1; we[u] = w; addr[u] = a; wd[u] = d;
        lat = -1;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (done[u]) begin
                lat = n - 1;
                break;
            end
        end
        o_acc = acc[u]; o_rd = rd[u]; o_wr = wr[u]; o_rdata = rdata[u];
        @(negedge clk);
        req[u] = 1'b0;
        @(posedge clk); #1;
        cleared = !done[u] && !acc[u] && !rd[u] && !wr[u];
    endtask

    int          lat;
    logic        a_acc, a_rd, a_wr, a_clr;
    logic [31:0] a_rdata;

    initial begin
        for (int u = 0; u < 2; u++) begin
            arst[u] = 1'b0; req[u] = 1'b0; we[u] = 1'b0; addr[u] = 64'h0; wd[u] = 32'h0;
        end

        vecs[0]  = '{0, 1'b1, 64'h10,   32'hDEADBEEF, 5, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[1]  = '{0, 1'b0, 64'h10,   32'h0,        5, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{0, 1'b0, 64'h12,   32'h0,        5, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{0, 1'b1, 64'h1000, 32'h12345678, 5, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{0, 1'b0, 64'h10,   32'h0,        5, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[5]  = '{0, 1'b0, 64'h1000, 32'h0,        5, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{0, 1'b1, 64'h11,   32'hBADBAD00, 5, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{0, 1'b0, 64'h10,   32'h0,        5, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[8]  = '{0, 1'b1, 64'hFFC,  32'hCAFEF00D, 5, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[9]  = '{0, 1'b0, 64'hFFC,  32'h0,        5, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D};
        vecs[10] = '{0, 1'b1, 64'h20,   32'h13572468, 5, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[11] = '{0, 1'b0, 64'h20,   32'h0,        5, 1'b1, 1'b1, 1'b0, 32'h13572468};
        vecs[12] = '{1, 1'b1, 64'h0,    32'h1,        1, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[13] = '{1, 1'b0, 64'h0,    32'h0,        1, 1'b1, 1'b1, 1'b0, 32'h1};

        // Reset state, both instances
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst%0d outputs", u),
                  {60'h0, done[u], acc[u], rd[u], wr[u]}, 64'h0);
            check($sformatf("rst%0d rdata", u), {32'h0, rdata[u]}, 64'h0);
        end
        @(negedge clk);
        arst[0] = 1'b1; arst[1] = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_access(vecs[i].u, vecs[i].w, vecs[i].a, vecs[i].d, lat, a_acc, a_rd, a_wr, a_rdata, a_clr);
            check_lat($sformatf("v%0d lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d flags", i), {61'h0, a_acc, a_rd, a_wr},
                  {61'h0, vecs[i].acc, vecs[i].rd, vecs[i].wr});
            check($sformatf("v%0d rdata", i), {32'h0, a_rdata}, {32'h0, vecs[i].rdata});
            check($sformatf("v%0d cleared", i), {63'h0, a_clr}, 64'h1);
        end

        // Hold request through RESP on LATENCY=0 while changing inputs: no second access
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 64'h4; wd[1] = 32'h77;
        lat = -1;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (done[1]) begin lat = n - 1; break; end
        end
        check_lat("hold lat", lat, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            we[1] = 1'b0; addr[1] = 64'h8; wd[1] = 32'h99;
            @(posedge clk); #1;
            check($sformatf("hold%0d done/wr", k), {62'h0, done[1], wr[1]}, 64'h3);
        end
        @(negedge clk);
        req[1] = 1'b0;
        do_access(1, 1'b0, 64'h4, 32'h0, lat, a_acc, a_rd, a_wr, a_rdata, a_clr);
        check("hold readback", {32'h0, a_rdata}, 64'h77);

        // Drop request during WAIT: access completes, RESP exits on the next edge
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 64'h30; wd[0] = 32'hA5A5A5A5;
        lat = -1;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (done[0]) begin lat = n - 1; break; end
            if (n == 2) begin @(negedge clk); req[0] = 1'b0; end
        end
        check_lat("drop lat", lat, 5);
        check("drop wr", {63'h0, wr[0]}, 64'h1);
        @(posedge clk); #1;
        check("drop exit", {63'h0, done[0]}, 64'h0);
        do_access(0, 1'b0, 64'h30, 32'h0, lat, a_acc, a_rd, a_wr, a_rdata, a_clr);
        check("drop readback", {32'h0, a_rdata}, 64'hA5A5A5A5);

        // Reset mid-WAIT aborts a write of 0x55 to 0x20
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 64'h20; wd[0] = 32'h55;
        repeat (3) @(posedge clk);
        #2;
        arst[0] = 1'b0;
        #1;
        check("midrst outputs", {60'h0, done[0], acc[0], rd[0], wr[0]}, 64'h0);
        check("midrst rdata", {32'h0, rdata[0]}, 64'h0);
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        arst[0] = 1'b1;
        do_access(0, 1'b0, 64'h20, 32'h0, lat, a_acc, a_rd, a_wr, a_rdata, a_clr);
        check_lat("midrst lat", lat, 5);
        check("midrst readback", {32'h0, a_rdata}, 64'h13572468);

`ifdef MEM_RANDOM_STALL_EN
        begin
            logic [31:0] sb    [64];
            logic        valid [64];
            int          wi;
            logic        w;
            logic [31:0] d;
            for (int i = 0; i < 64; i++) valid[i] = 1'b0;
            for (int i = 0; i < 100; i++) begin
                wi = $urandom_range(0, 63);
                w  = ($urandom_range(0, 1) == 1) || !valid[wi];
                d  = $urandom;
                do_access(0, w, 64'(32'h100 + wi * 4), d, lat, a_acc, a_rd, a_wr, a_rdata, a_clr);
                check_lat($sformatf("rnd%0d lat", i), lat, 5);
                check($sformatf("rnd%0d flags", i), {61'h0, a_acc, a_rd, a_wr}, {61'h0, 1'b1, !w, w});
                if (w) begin
                    sb[wi] = d; valid[wi] = 1'b1;
                end else begin
                    check($sformatf("rnd%0d rdata", i), {32'h0, a_rdata}, {32'h0, sb[wi]});
                end
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
